// File: rtl/aemb2_bus_pkg.sv
// Shared definitions for the aeMB2 bus arbiter.
// State encoding, bus data width and default watchdog limit.
package aemb2_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int WB_DW = 32;
    localparam int TO_CYC_DEF = 255;

endpackage

// File: rtl/aemb2_busarb_rr.sv
// Two-way round-robin grant FSM for the aeMB2 bus arbiter.
// Owner changes always pass through IDLE for one clock.
module aemb2_busarb_rr
    import aemb2_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cyc0,
    input  logic       cyc1,
    output arb_state_t state,
    output logic       last
);

    arb_state_t nxt;
    logic       last_nxt;

    // state and last-owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= nxt;
            last  <= last_nxt;
        end
    end

    // grant selection; ties go to the master not served last
    always_comb begin
        nxt      = state;
        last_nxt = last;
        unique case (state)
            IDLE: begin
                if (cyc0 && cyc1) begin
                    nxt = last ? GNT0 : GNT1;
                end else if (cyc0) begin
                    nxt = GNT0;
                end else if (cyc1) begin
                    nxt = GNT1;
                end
            end
            GNT0: begin
                if (!cyc0) begin
                    nxt      = IDLE;
                    last_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!cyc1) begin
                    nxt      = IDLE;
                    last_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/aemb2_busarb.sv
// Two-master Wishbone arbiter and slave decoder for aeMB2.
// Optional watchdog: define AEMB2_BUSARB_TIMEOUT_EN.
module aemb2_busarb
    import aemb2_bus_pkg::*;
#(
    parameter int AW     = 32,
    parameter int NSLV   = 4,
    parameter int SW     = 2,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic [AW-1:2]         m0_adr_i,
    input  logic [WB_DW-1:0]      m0_dat_i,
    input  logic [3:0]            m0_sel_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_wre_i,
    input  logic                  m0_cyc_i,
    output logic [WB_DW-1:0]      m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [AW-1:2]         m1_adr_i,
    input  logic [WB_DW-1:0]      m1_dat_i,
    input  logic [3:0]            m1_sel_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_wre_i,
    input  logic                  m1_cyc_i,
    output logic [WB_DW-1:0]      m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [AW-1:2]         slv_adr_o,
    output logic [WB_DW-1:0]      slv_dat_o,
    output logic [3:0]            slv_sel_o,
    output logic                  slv_wre_o,
    output logic                  slv_cyc_o,
    output logic [NSLV-1:0]       slv_stb_o,
    input  logic [NSLV*WB_DW-1:0] slv_dat_i,
    input  logic [NSLV-1:0]       slv_ack_i,
    output logic [1:0]            arb_gnt_o
`ifdef AEMB2_BUSARB_TIMEOUT_EN
    ,
    output logic                  to_flag_o
`endif
);

    arb_state_t        state;
    logic              last;
    logic              unused_last;

    logic              own0;
    logic              own1;
    logic [AW-1:2]     g_adr;
    logic [WB_DW-1:0]  g_dat;
    logic [3:0]        g_sel;
    logic              g_wre;
    logic              g_cyc;
    logic              g_stb;

    logic [SW-1:0]     idx;
    logic              mapped;
    logic [NSLV-1:0]   stb_vec;
    logic              ack_sel;
    logic [WB_DW-1:0]  dat_sel;
    logic              hit_ack;
    logic [WB_DW-1:0]  rd;

    logic [1:0]        err_q;
    logic              to_err;
    logic              g_err;

    aemb2_busarb_rr u_rr (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .cyc0  (m0_cyc_i),
        .cyc1  (m1_cyc_i),
        .state (state),
        .last  (last)
    );

    assign unused_last = last;
    assign own0 = (state == GNT0);
    assign own1 = (state == GNT1);
    assign arb_gnt_o = {own1, own0};

    // forward the granted master; a dropped cyc kills stb at once
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_wre = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        unique case (1'b1)
            own0: begin
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
                g_sel = m0_sel_i;
                g_wre = m0_wre_i;
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i & m0_cyc_i;
            end
            own1: begin
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
                g_sel = m1_sel_i;
                g_wre = m1_wre_i;
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i & m1_cyc_i;
            end
            default: ;
        endcase
    end

    assign idx    = g_adr[AW-1 -: SW];
    assign mapped = int'(idx) < NSLV;

    // one-hot strobe and read-back select for the decoded slave
    always_comb begin
        stb_vec = '0;
        ack_sel = 1'b0;
        dat_sel = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx == SW'(k)) begin
                stb_vec[k] = g_stb & ~to_err;
                ack_sel    = slv_ack_i[k];
                dat_sel    = slv_dat_i[k*WB_DW +: WB_DW];
            end
        end
    end

    assign hit_ack = ack_sel & (|stb_vec);
    assign rd      = hit_ack ? dat_sel : '0;

    assign slv_adr_o = g_adr;
    assign slv_dat_o = g_dat;
    assign slv_sel_o = g_sel;
    assign slv_cyc_o = g_cyc;
    assign slv_stb_o = stb_vec;
    assign slv_wre_o = g_wre & (|stb_vec);

    // one-clock error for a strobe into unmapped space
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            err_q <= '0;
        end else begin
            err_q[0] <= own0 & g_stb & ~mapped & ~err_q[0];
            err_q[1] <= own1 & g_stb & ~mapped & ~err_q[1];
        end
    end

    assign g_err = (own0 & err_q[0])
                 | (own1 & err_q[1])
                 | to_err;

    assign m0_ack_o = own0 & hit_ack;
    assign m0_err_o = own0 & g_err;
    assign m0_dat_o = own0 ? rd : '0;
    assign m1_ack_o = own1 & hit_ack;
    assign m1_err_o = own1 & g_err;
    assign m1_dat_o = own1 ? rd : '0;

`ifdef AEMB2_BUSARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_flag_q;

    assign to_err    = g_stb & (to_cnt == 8'(TO_CYC));
    assign to_flag_o = to_flag_q;

    // watchdog on a stalled strobe, plus sticky timeout status
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            to_cnt    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (!g_stb || hit_ack || g_err) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (to_err) begin
                to_flag_q <= 1'b1;
            end
        end
    end
`else
    localparam int unused_to = TO_CYC;
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_aemb2_busarb.sv
// Self-checking bench for aemb2_busarb (NSLV=3, TO_CYC=8).
// Cycle model compared every clock plus literal spot checks.
module tb_aemb2_busarb;

`ifdef AEMB2_BUSARB_TIMEOUT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] m0_adr, m1_adr;
    logic [31:0] m0_dat, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_stb, m0_wre, m0_cyc;
    logic        m1_stb, m1_wre, m1_cyc;
    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [29:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic        s_wre, s_cyc;
    logic [2:0]  s_stb;
    logic [95:0] slv_dat;
    logic [2:0]  slv_ack;
    logic [1:0]  gnt;
    logic        to_flag;

    int n_checks = 0;
    int n_errors = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    aemb2_busarb #(
        .AW(32), .NSLV(3), .SW(2), .TO_CYC(TO)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_dat),
        .m0_sel_i  (m0_sel),
        .m0_stb_i  (m0_stb),
        .m0_wre_i  (m0_wre),
        .m0_cyc_i  (m0_cyc),
        .m0_dat_o  (m0_rd),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_dat),
        .m1_sel_i  (m1_sel),
        .m1_stb_i  (m1_stb),
        .m1_wre_i  (m1_wre),
        .m1_cyc_i  (m1_cyc),
        .m1_dat_o  (m1_rd),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .slv_adr_o (s_adr),
        .slv_dat_o (s_dat),
        .slv_sel_o (s_sel),
        .slv_wre_o (s_wre),
        .slv_cyc_o (s_cyc),
        .slv_stb_o (s_stb),
        .slv_dat_i (slv_dat),
        .slv_ack_i (slv_ack),
        .arb_gnt_o (gnt)
`ifdef AEMB2_BUSARB_TIMEOUT_EN
        ,
        .to_flag_o (to_flag)
`endif
    );

`ifndef AEMB2_BUSARB_TIMEOUT_EN
    assign to_flag = 1'b0;
`endif

    // model state: who owns the bus, who was last, pending error
    int owner;
    bit last_m;
    bit epend;
    int eown;
    int cnt;
    bit tflag;

    // model outputs for the current cycle
    logic [29:0] e_adr;
    logic [31:0] e_dat, e_rd;
    logic [3:0]  e_sel;
    logic        e_wre, e_cyc, e_go, e_map;
    logic        e_ack, e_err, e_terr;
    logic [2:0]  e_stb;
    logic [1:0]  e_gnt;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic eval();
        logic st;
        int   ix;
        e_adr = '0;
        e_dat = '0;
        e_sel = '0;
        st    = 1'b0;
        e_wre = 1'b0;
        e_cyc = 1'b0;
        if (owner == 0) begin
            e_adr = m0_adr; e_dat = m0_dat; e_sel = m0_sel;
            st = m0_stb; e_wre = m0_wre; e_cyc = m0_cyc;
        end else if (owner == 1) begin
            e_adr = m1_adr; e_dat = m1_dat; e_sel = m1_sel;
            st = m1_stb; e_wre = m1_wre; e_cyc = m1_cyc;
        end
        e_go   = st && e_cyc;
        ix     = int'(e_adr[29:28]);
        e_map  = ix < 3;
        e_terr = FEAT && e_go && cnt == TO;
        e_stb  = (e_go && e_map && !e_terr) ? 3'(1 << ix) : 3'b000;
        e_ack  = 1'b0;
        if (e_stb != 0) e_ack = slv_ack[ix];
        e_rd   = e_ack ? slv_dat[ix*32 +: 32] : 32'h0;
        e_err  = (owner >= 0 && epend && eown == owner) || e_terr;
        e_wre  = e_wre && (e_stb != 0);
        e_gnt  = owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00;
    endtask

    // advance the model on each rising edge
    always @(posedge clk) begin
        eval();
        if (rst) begin
            owner = -1; last_m = 1'b1; epend = 1'b0;
            eown = -1; cnt = 0; tflag = 1'b0;
        end else begin
            if (owner >= 0 && e_go && !e_map && !(epend && eown == owner)) begin
                epend = 1'b1; eown = owner;
            end else begin
                epend = 1'b0;
            end
            if (!e_go || e_ack || e_err) cnt = 0;
            else cnt = cnt + 1;
            if (e_terr) tflag = 1'b1;
            if (owner < 0) begin
                if (m0_cyc && m1_cyc) owner = last_m ? 0 : 1;
                else if (m0_cyc) owner = 0;
                else if (m1_cyc) owner = 1;
            end else if ((owner == 0 && !m0_cyc) || (owner == 1 && !m1_cyc)) begin
                last_m = (owner == 1);
                owner = -1;
            end
        end
    end

    // compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (run) begin
            eval();
            chk("gnt", gnt, e_gnt);
            chk("slv_stb", s_stb, e_stb);
            chk("slv_adr", s_adr, e_adr);
            chk("slv_dat", s_dat, e_dat);
            chk("slv_sel", s_sel, e_sel);
            chk("slv_wre", s_wre, e_wre);
            chk("slv_cyc", s_cyc, e_cyc);
            chk("m0_ack", m0_ack, owner == 0 && e_ack);
            chk("m0_err", m0_err, owner == 0 && e_err);
            chk("m0_dat", m0_rd, owner == 0 ? e_rd : 32'h0);
            chk("m1_ack", m1_ack, owner == 1 && e_ack);
            chk("m1_err", m1_err, owner == 1 && e_err);
            chk("m1_dat", m1_rd, owner == 1 ? e_rd : 32'h0);
            if (FEAT) chk("to_flag", to_flag, tflag);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        m0_cyc = 0; m0_stb = 0; m0_wre = 0;
        m1_cyc = 0; m1_stb = 0; m1_wre = 0;
        slv_ack = '0;
    endtask

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0;
        slv_dat = '0;
        idle_all();
        tick();
        run = 1'b1;
        settle();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_stb", s_stb, 3'b000);
        tick();
        rst = 1'b0;

        // single-master read from RAM
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h40;
        settle();
        chk("t1_latency", gnt, 2'b00);
        tick();
        slv_ack = 3'b001;
        slv_dat[31:0] = 32'hCAFEF00D;
        settle();
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_stb", s_stb, 3'b001);
        chk("t1_dat", m0_rd, 32'hCAFEF00D);
        chk("t1_ack", m0_ack, 1'b1);
        chk("t1_m1_ack", m1_ack, 1'b0);
        tick();
        idle_all();
        tick();
        slv_ack = 3'b111;
        settle();
        chk("stray_ack0", m0_ack, 1'b0);
        chk("stray_ack1", m1_ack, 1'b0);
        tick();
        slv_ack = '0;

        // round-robin out of reset
        rst = 1;
        tick();
        rst = 0;
        m0_cyc = 1; m1_cyc = 1;
        tick();
        settle();
        chk("rr_first", gnt, 2'b01);
        tick();
        m0_cyc = 0;
        tick();
        settle();
        chk("rr_gap", gnt, 2'b00);
        tick();
        settle();
        chk("rr_m1", gnt, 2'b10);
        m1_cyc = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        settle();
        chk("rr_alt", gnt, 2'b01);
        idle_all();
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        settle();
        chk("rr_m1_turn", gnt, 2'b10);
        idle_all();
        tick();
        tick();

        // peripheral write from XWB
        m1_cyc = 1; m1_stb = 1; m1_wre = 1;
        m1_sel = 4'b0001; m1_dat = 32'h5A;
        m1_adr = 30'h1000_0001;
        tick();
        slv_ack = 3'b010;
        settle();
        chk("t3_stb", s_stb, 3'b010);
        chk("t3_wre", s_wre, 1'b1);
        chk("t3_dat", s_dat, 32'h0000_005A);
        chk("t3_sel", s_sel, 4'b0001);
        chk("t3_m1_ack", m1_ack, 1'b1);
        chk("t3_m0_ack", m0_ack, 1'b0);
        tick();
        idle_all();
        m1_sel = '0; m1_dat = '0;
        tick();
        settle();
        chk("t3_wre_idle", s_wre, 1'b0);
        tick();

        // unmapped access errors after one clock
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h3000_0000;
        tick();
        settle();
        chk("t4_gnt", gnt, 2'b01);
        chk("t4_nostb", s_stb, 3'b000);
        chk("t4_err0", m0_err, 1'b0);
        tick();
        settle();
        chk("t4_err1", m0_err, 1'b1);
        chk("t4_ack", m0_ack, 1'b0);
        chk("t4_dat", m0_rd, 32'h0);
        tick();
        settle();
        chk("t4_err2", m0_err, 1'b0);
        idle_all();
        tick();
        tick();

        // slave 2 stall: watchdog, or late ack
        m0_cyc = 1; m0_stb = 1; m0_adr = 30'h2000_0000;
        tick();
        settle();
        chk("t5_stb", s_stb, 3'b100);
        if (FEAT) begin
            repeat (7) tick();
            settle();
            chk("t5_pre", m0_err, 1'b0);
            tick();
            settle();
            chk("t5_err", m0_err, 1'b1);
            chk("t5_drop", s_stb, 3'b000);
            tick();
            settle();
            chk("t5_clr", m0_err, 1'b0);
            chk("t5_flag", to_flag, 1'b1);
            idle_all();
            tick();
            tick();
            settle();
            chk("t5_sticky", to_flag, 1'b1);
        end else begin
            repeat (3) tick();
            slv_ack = 3'b100;
            slv_dat[95:64] = 32'h1234_5678;
            settle();
            chk("t5_ack", m0_ack, 1'b1);
            chk("t5_dat", m0_rd, 32'h1234_5678);
            tick();
            idle_all();
            tick();
        end

        // reset in the middle of an M1 access
        m1_cyc = 1; m1_stb = 1; m1_adr = 30'h1000_0000;
        tick();
        settle();
        chk("t6_gnt", gnt, 2'b10);
        tick();
        rst = 1;
        tick();
        settle();
        chk("t6_gnt0", gnt, 2'b00);
        chk("t6_stb0", s_stb, 3'b000);
        chk("t6_m1ack", m1_ack, 1'b0);
        chk("t6_m1err", m1_err, 1'b0);
        chk("t6_m0err", m0_err, 1'b0);
        if (FEAT) chk("t6_flag", to_flag, 1'b0);
        rst = 0;
        m0_cyc = 1;
        tick();
        settle();
        chk("t6_rr", gnt, 2'b01);
        idle_all();
        tick();
        tick();

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aemb2_busarb.md
Name: aemb2_busarb

Overview:
- Parametrised two-master Wishbone arbiter and address decoder for the aeMB2 core.
- Masters: M0 is the data bus (DWB); M1 is the extension bus (XWB).
- Slaves: NSLV slaves, where slave 0 is on-chip RAM and slaves 1..NSLV-1 are I/O devices such as GPIO or UART.
- Replaces the fixed DWB-only RAM/GPIO split with:
  - round-robin arbitration,
  - a parametrised decode field,
  - error termination of unmapped accesses,
  - an optional watchdog timeout.

Parameters:
- AW, 32, byte-address width; address ports carry bits [AW-1:2].
- NSLV, 4, number of slaves, 2..2^SW.
- SW, 2, decode field width; the slave index is adr[AW-1 -: SW].
- TO_CYC, 255, watchdog limit in clocks (8-bit counter, 1..255).

Ports:
- sys_clk_i  in  1  system clock; all logic is on the rising edge.
- sys_rst_i  in  1  synchronous reset, active-high.
- m0_adr_i   in  AW-2  DWB address [AW-1:2].
- m0_dat_i   in  32  DWB write data.
- m0_sel_i   in  4  DWB byte selects.
- m0_stb_i   in  1  DWB strobe.
- m0_wre_i   in  1  DWB write enable.
- m0_cyc_i   in  1  DWB cycle.
- m0_dat_o   out  32  DWB read data.
- m0_ack_o   out  1  DWB acknowledge.
- m0_err_o   out  1  DWB error.
- m1_* ports: identical set for XWB.
- slv_adr_o  out  AW-2  shared slave address.
- slv_dat_o  out  32  shared slave write data.
- slv_sel_o  out  4  shared slave byte selects.
- slv_wre_o  out  1  shared slave write enable.
- slv_cyc_o  out  1  shared slave cycle.
- slv_stb_o  out  NSLV  one-hot slave strobes.
- slv_dat_i  in  NSLV*32  slave read data; slave k occupies [32k+31:32k].
- slv_ack_i  in  NSLV  slave acknowledges.
- arb_gnt_o  out  2  current grant; one-hot or 00.

Behaviour:

State machine: IDLE, GNT0, GNT1. State is registered.
- IDLE:
  - m0_cyc_i and m1_cyc_i both low: stay IDLE.
  - Only one cyc high: grant that master.
  - Both high: grant the master opposite to `last`, a 1-bit register holding the last-granted master; `last` resets to 1, so M0 wins first.
- GNTn:
  - Stay while mn_cyc_i is high.
  - When mn_cyc_i drops, go to IDLE and set last=n. No direct GNT0-to-GNT1 hop; this gives one idle clock between owners.
- Grant latency: one clock from cyc rising in IDLE.
- The ungranted master sees ack=err=0 and dat=0.

Routing (combinational from state):
- slv_adr/dat/sel/wre/cyc come from the granted master; all are zero in IDLE.
- idx = granted adr[AW-1 -: SW].
- slv_stb_o[idx] = granted stb when idx<NSLV; all other strobes are 0.
- Granted master: ack = slv_ack_i[idx] and dat = slave idx data, masked to 0 when ack is low.
- Writes forward only while granted. slv_wre_o is 0 whenever no strobe is active.

Unmapped access (idx>=NSLV):
- No slave strobe is asserted.
- Exactly one clock after stb is seen high with the grant held, the master gets err=1 and ack=0 for one clock, with dat=0.
- The err pulse is generated by a registered flag that clears the following clock.

Other rules:
- A slave ack while its strobe is low is ignored.
- If a master drops cyc mid-access, its strobe is removed in the same clock. The slave ack, if late, is ignored.
- Reset mid-transfer takes effect at the next edge: state=IDLE, last=1, counters=0.
- All registered outputs are 0 after reset. Combinational outputs are 0 in IDLE.

Optional Feature:
- Macro: AEMB2_BUSARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each clock that the granted stb is high with no ack and no err.
  - The counter clears on ack, on err, or when stb is low.
  - When the count reaches TO_CYC, the master gets a one-clock err=1 and the slave strobe is dropped that clock.
  - Sticky status output to_flag_o (1 bit) sets on the timeout and clears only on reset.
- Undefined: there is no counter and no to_flag_o port, and a mapped access waits for ack indefinitely.

Decomposition:
- Shared package aemb2_bus_pkg holds:
  - the state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2);
  - the WB data width of 32;
  - the default TO_CYC.
- One natural sub-module, aemb2_busarb_rr: the 2-way round-robin grant FSM with `last` register, which exposes its grant state and `last` register.
- Decode/mux and the error/timeout logic stay in the top module.

Test Plan:
- Single master read: M0 cyc/stb at adr 0x0000_0100 → arb_gnt_o=01 after 1 clk; slv_stb_o=0001; slave 0 acks with 0xCAFEF00D → m0_dat_o=0xCAFEF00D and m0_ack_o=1 in the same clock.
- Simultaneous request out of reset: both cyc rise together → M0 granted; on M0 cyc drop, one IDLE clock, then M1 granted. Repeat with both requesting → M0 next (alternation holds).
- Peripheral write: M1 writes 0x5A to adr 0x4000_0004, with sel=0001 → slv_stb_o=0010, slv_wre_o=1, slv_dat_o=0x0000005A; slave 1 ack propagates to m1_ack_o only.
- Unmapped access: NSLV=3, M0 reads adr 0xC000_0000 → no slave strobe; m0_err_o=1 for exactly one clock, 1 clk after stb.
- Timeout (feature on, TO_CYC=8): M0 strobes slave 2, which never acks → m0_err_o pulses at count 8; to_flag_o=1 and stays 1 until sys_rst_i.
- Reset mid-access: assert sys_rst_i while GNT1 with stb high → next clock arb_gnt_o=00, slv_stb_o=0, all acks/errs 0, and the next simultaneous request grants M0.
